// File: rtl/seg_display_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// scan FSM states, segment encodings and the hex glyph table.
package seg_display_pkg;

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   // Segment vectors are active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] HEX_TABLE [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module seg_hex_decode
   import seg_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = HEX_TABLE[nibble];

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment display driver with a frame-buffered write port.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_display_mux
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               wr_valid,
   output logic                               wr_ready,
   input  logic [4*NUM_DIGITS-1:0]            wr_data,
   input  logic [NUM_DIGITS-1:0]              wr_dp,
   input  logic [NUM_DIGITS-1:0]              blank_mask,
   output logic [6:0]                         seg_n,
   output logic                               dp_n,
   output logic [NUM_DIGITS-1:0]              an_n,
   output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(REFRESH_DIV);

   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic [IDX_W-1:0]        scan_reg, scan_next;
   logic [0:0]              state_reg, state_next;
   logic                    pend_full_reg;
   logic [4*NUM_DIGITS-1:0] pend_data_reg, act_data_reg;
   logic [NUM_DIGITS-1:0]   pend_dp_reg, act_dp_reg;
   logic [6:0]              seg_n_reg;
   logic                    dp_n_reg;
   logic [NUM_DIGITS-1:0]   an_n_reg;

   logic                    cnt_last, scan_last, frame_end, accept;
   logic [3:0]              nib [NUM_DIGITS];
   logic [3:0]              cur_nib;
   logic [6:0]              dec_seg;
   logic                    lz_dark, digit_dark;

   always_comb begin
      cnt_last   = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
      scan_last  = (scan_reg == IDX_W'(NUM_DIGITS - 1));
      frame_end  = cnt_last && scan_last;
      accept     = wr_valid && !pend_full_reg;
      cnt_next   = cnt_last ? '0 : cnt_reg + 1'b1;
      scan_next  = scan_reg;
      if (cnt_last) begin
         scan_next = scan_last ? '0 : scan_reg + 1'b1;
      end
      // The state tracks the counter value it will sit beside next cycle
      state_next = (cnt_next < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_reg   <= '0;
         scan_reg  <= '0;
         state_reg <= ST_BLANK;
      end else begin
         cnt_reg   <= cnt_next;
         scan_reg  <= scan_next;
         state_reg <= state_next;
      end
   end

   // Pending is only ever loaded while empty, so a capture on the boundary
   // cycle never collides with the pending-to-active transfer.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_full_reg <= 1'b0;
         pend_data_reg <= '0;
         pend_dp_reg   <= '0;
         act_data_reg  <= '0;
         act_dp_reg    <= '0;
      end else begin
         if (frame_end && pend_full_reg) begin
            act_data_reg  <= pend_data_reg;
            act_dp_reg    <= pend_dp_reg;
            pend_full_reg <= 1'b0;
         end
         if (accept) begin
            pend_data_reg <= wr_data;
            pend_dp_reg   <= wr_dp;
            pend_full_reg <= 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
         assign nib[gi] = act_data_reg[4*gi +: 4];
      end
   endgenerate

   assign cur_nib = nib[scan_reg];

   seg_hex_decode u_dec (
      .nibble (cur_nib),
      .seg_n  (dec_seg)
   );

`ifdef SEG_LZ_BLANK_EN
   // lz[i]: digit i and everything above it are zero; digit 0 never qualifies
   logic [NUM_DIGITS-1:0] lz;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
         if (gi == 0) begin : g_lsd
            assign lz[gi] = 1'b0;
         end else begin : g_upper
            assign lz[gi] = (act_data_reg[4*NUM_DIGITS-1:4*gi] == '0);
         end
      end
   endgenerate
   assign lz_dark = lz[scan_reg] && !act_dp_reg[scan_reg];
`else
   assign lz_dark = 1'b0;
`endif

   assign digit_dark = blank_mask[scan_reg] || lz_dark;

   always_ff @(posedge CLK) begin
      if (RST || state_reg == ST_BLANK) begin
         seg_n_reg <= SEG_OFF;
         dp_n_reg  <= 1'b1;
         an_n_reg  <= '1;
      end else begin
         seg_n_reg <= dec_seg;
         dp_n_reg  <= ~act_dp_reg[scan_reg];
         an_n_reg  <= digit_dark ? '1 : ~(NUM_DIGITS'(1) << scan_reg);
      end
   end

   assign wr_ready = ~pend_full_reg;
   assign seg_n    = seg_n_reg;
   assign dp_n     = dp_n_reg;
   assign an_n     = an_n_reg;
   assign scan_idx = scan_reg;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux: directed scenarios plus random
// frames, compared every cycle against a time-arithmetic display model.
module tb_seg_display_mux;

   localparam int N = 4;
   localparam int R = 8;
   localparam int B = 2;

   // Active-high segment glyphs {g,f,e,d,c,b,a}; DUT outputs are their inverse
   localparam logic [6:0] SEG_HI [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [15:0]   wr_data = '0;
   logic [3:0]    wr_dp = '0;
   logic [3:0]    blank_mask = '0;
   logic [6:0]    seg_n;
   logic          dp_n;
   logic [3:0]    an_n;
   logic [1:0]    scan_idx;

   int vectors = 0;
   int errs    = 0;

   // Model: elapsed cycles since reset plus the two frame buffers
   int          m_t = 0;
   logic        m_pend_full = 1'b0;
   logic [15:0] m_pend_data = '0, m_act_data = '0;
   logic [3:0]  m_pend_dp = '0, m_act_dp = '0;

   seg_display_mux #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (R),
      .BLANK_CYCLES (B)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .wr_dp      (wr_dp),
      .blank_mask (blank_mask),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .scan_idx   (scan_idx)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
      end
   endtask

   function automatic bit at_boundary();
      return (m_t % R) == R - 1 && ((m_t / R) % N) == N - 1;
   endfunction

   task automatic step();
      int pos, slot, nib, msd;
      logic dark;
      logic [6:0] es;
      logic ed, er;
      logic [3:0] ea;
      logic [1:0] esc;
      pos  = m_t % R;
      slot = (m_t / R) % N;
      es = 7'h7F; ed = 1'b1; ea = 4'hF;
      if (!RST && pos >= B) begin
         nib  = int'((m_act_data >> (4 * slot)) & 16'hF);
         es   = ~SEG_HI[nib];
         ed   = ~m_act_dp[slot];
         dark = blank_mask[slot];
`ifdef SEG_LZ_BLANK_EN
         msd = 0;
         for (int i = 0; i < N; i++) if (((m_act_data >> (4 * i)) & 16'hF) != 0) msd = i;
         if (slot > msd && !m_act_dp[slot]) dark = 1'b1;
`endif
         ea = dark ? 4'hF : ~(4'b0001 << slot);
      end
      @(posedge CLK);
      if (RST) begin
         m_t = 0;
         m_pend_full = 1'b0;
         m_act_data = '0;
         m_act_dp = '0;
      end else begin
         if (pos == R - 1 && slot == N - 1 && m_pend_full) begin
            m_act_data  = m_pend_data;
            m_act_dp    = m_pend_dp;
            m_pend_full = 1'b0;
         end else if (wr_valid && !m_pend_full) begin
            m_pend_data = wr_data;
            m_pend_dp   = wr_dp;
            m_pend_full = 1'b1;
         end
         m_t++;
      end
      er  = !m_pend_full;
      esc = 2'((m_t / R) % N);
      #1;
      chk("seg_n", 32'(seg_n), 32'(es));
      chk("dp_n", 32'(dp_n), 32'(ed));
      chk("an_n", 32'(an_n), 32'(ea));
      chk("scan_idx", 32'(scan_idx), 32'(esc));
      chk("wr_ready", 32'(wr_ready), 32'(er));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      bit found;
      int k;
      logic [15:0] frames [2];

      // Reset, then a known frame
      RST = 1'b1;
      run(3);
      RST = 1'b0;
      wr_valid = 1'b1; wr_data = 16'h1234; wr_dp = 4'b0000;
      step();
      wr_valid = 1'b0;
      run(80);

      // Back-to-back frames held valid until each is taken
      frames[0] = 16'($urandom); frames[1] = 16'($urandom);
      k = 0;
      for (int i = 0; i < 100 && k < 2; i++) begin
         wr_valid = 1'b1; wr_data = frames[k]; wr_dp = 4'($urandom);
         found = !m_pend_full;
         step();
         if (found) k++;
      end
      chk("b2b_bound", 32'(k), 32'd2);
      wr_valid = 1'b0;
      run(70);

      // Offer exactly on the frame boundary cycle
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (at_boundary() && !m_pend_full) found = 1'b1;
         else step();
      end
      chk("boundary_bound", 32'(found), 32'd1);
      wr_valid = 1'b1; wr_data = 16'($urandom); wr_dp = 4'($urandom);
      step();
      wr_valid = 1'b0;
      run(70);

      // Leading-zero frame
      wr_valid = 1'b1; wr_data = 16'h0070; wr_dp = 4'b0000;
      step();
      wr_valid = 1'b0;
      run(70);

      // Masked digit, then reset mid-slot
      blank_mask = 4'b0100;
      run(40);
      for (int i = 0; i < R && (m_t % R) != 4; i++) step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      blank_mask = 4'b0000;
      run(40);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         wr_valid = ($urandom_range(0, 2) == 0);
         wr_data  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
         wr_dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
         RST = ($urandom_range(0, 149) == 0);
         step();
      end
      RST = 1'b0;
      wr_valid = 1'b0;
      run(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
